// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter in front of a shared write FIFO
// Optional per-requester accepted-beat counters: define FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int P_NUM_REQ    = 4,
  parameter int P_DATA_WIDTH = 8,
  parameter int P_BURST_MAX  = 8,
  parameter int P_BLEN_W     = $clog2(P_BURST_MAX) + 1
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [P_NUM_REQ-1:0]              i_req_valid,
  input  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] i_req_data,
  output logic [P_NUM_REQ-1:0]              o_req_ready,
  output logic                              o_fifo_wren,
  output logic [P_DATA_WIDTH-1:0]           o_fifo_wdata,
  input  logic                              i_fifo_full,
  input  logic [P_BLEN_W-1:0]               i_cfg_burst_len,
  output logic [$clog2(P_NUM_REQ)-1:0]      o_grant_id,
  output logic                              o_busy,
  output logic [P_NUM_REQ*16-1:0]           o_beat_cnt
);
  localparam int LP_ID_W = $clog2(P_NUM_REQ);
  localparam logic [P_BLEN_W-1:0] LP_BMAX = P_BLEN_W'(P_BURST_MAX);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_STALL} state_t;

  state_t               state_q;
  logic [LP_ID_W-1:0]   owner_q, rr_ptr_q, owner_d, rr_ptr_d, cand;
  logic [P_BLEN_W-1:0]  beats_q, limit_q, limit_d;
  logic                 found_d;

  // first valid requester at or above the round-robin pointer, with wrap
  always_comb begin
    found_d = 1'b0;
    owner_d = '0;
    cand    = '0;
    for (int i = 0; i < P_NUM_REQ; i++) begin
      cand = LP_ID_W'((int'(rr_ptr_q) + i) % P_NUM_REQ);
      if (!found_d && i_req_valid[cand]) begin
        found_d = 1'b1;
        owner_d = cand;
      end
    end
  end

  assign rr_ptr_d = (owner_d == LP_ID_W'(P_NUM_REQ - 1)) ? '0 : owner_d + LP_ID_W'(1);

  always_comb begin
    limit_d = i_cfg_burst_len;
    if (i_cfg_burst_len == '0)
      limit_d = P_BLEN_W'(1);
    else if (i_cfg_burst_len > LP_BMAX)
      limit_d = LP_BMAX;
  end

  always_comb begin
    o_req_ready = '0;
    if (state_q == S_BURST && !i_fifo_full)
      o_req_ready[owner_q] = 1'b1;
  end

  assign o_fifo_wren  = i_req_valid[owner_q] & o_req_ready[owner_q];
  assign o_fifo_wdata = o_fifo_wren ? i_req_data[int'(owner_q)*P_DATA_WIDTH +: P_DATA_WIDTH] : '0;
  assign o_busy       = (state_q != S_IDLE);
  assign o_grant_id   = owner_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      beats_q  <= '0;
      limit_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (found_d && !i_fifo_full) begin
            state_q  <= S_BURST;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            limit_q  <= limit_d;
            beats_q  <= '0;
          end
        end
        S_BURST: begin
          if (i_fifo_full) begin
            state_q <= S_STALL;
          end else if (!i_req_valid[owner_q]) begin
            state_q <= S_IDLE;
          end else begin
            beats_q <= beats_q + P_BLEN_W'(1);
            if (beats_q + P_BLEN_W'(1) == limit_q)
              state_q <= S_IDLE;
          end
        end
        S_STALL: begin
          if (!i_fifo_full)
            state_q <= S_BURST;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar k = 0; k < P_NUM_REQ; k++) begin : g_stat
    logic [15:0] cnt_q;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
        cnt_q <= '0;
      else if (i_req_valid[k] && o_req_ready[k] && cnt_q != 16'hFFFF)
        cnt_q <= cnt_q + 16'd1;
    end
    assign o_beat_cnt[k*16 +: 16] = cnt_q;
  end
`else
  assign o_beat_cnt = '0;
`endif

endmodule
